// File: rtl/cr_huf_comp_is_sort.sv
// Insertion sorter for the Huffman compressor: keeps (symbol, count) pairs ordered by count, drains on end-of-block.
// Optional zero-count filtering is enabled by defining CR_HUF_COMP_IS_ZERO_FILTER_EN.
module cr_huf_comp_is_sort #(
  parameter int DAT_WIDTH   = 9,
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_SYM     = 32,
  parameter int SEQID_WIDTH = 4,
  parameter int DESCEND     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sc_is_vld,
  input  logic [DAT_WIDTH-1:0]           sc_is_sym,
  input  logic [CNT_WIDTH-1:0]           sc_is_cnt,
  input  logic [SEQID_WIDTH-1:0]         sc_is_seq_id,
  input  logic                           sc_is_eob,
  output logic                           is_sc_rd,
  output logic                           is_ht_vld,
  output logic [DAT_WIDTH-1:0]           is_ht_sym,
  output logic [CNT_WIDTH-1:0]           is_ht_cnt,
  output logic                           is_ht_last,
  output logic [SEQID_WIDTH-1:0]         is_ht_seq_id,
  output logic [$clog2(MAX_SYM+1)-1:0]   is_ht_num_sym,
  output logic                           is_ht_ovfl,
  output logic                           is_ht_empty,
  input  logic                           ht_is_not_ready
);

  localparam int NUM_W = $clog2(MAX_SYM + 1);
  localparam int IDX_W = $clog2(MAX_SYM);
  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  localparam logic [NUM_W-1:0] NUM_MAX = NUM_W'(MAX_SYM);

  logic [0:0]             state_q, state_d;
  logic [MAX_SYM-1:0]     vld_q, vld_d;
  logic [DAT_WIDTH-1:0]   sym_q [MAX_SYM];
  logic [DAT_WIDTH-1:0]   sym_d [MAX_SYM];
  logic [CNT_WIDTH-1:0]   cnt_q [MAX_SYM];
  logic [CNT_WIDTH-1:0]   cnt_d [MAX_SYM];
  logic [NUM_W-1:0]       num_q, num_d;
  logic                   ovfl_q, ovfl_d;
  logic [IDX_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [SEQID_WIDTH-1:0] seq_q, seq_d;

  logic [MAX_SYM-1:0] after_s;
  logic accept_s, keep_s, full_s, ins_s, drop_s, drain_s, xfer_s, last_s;

  assign drain_s  = (state_q == ST_DRAIN);
  assign accept_s = sc_is_vld && (state_q == ST_FILL);
`ifdef CR_HUF_COMP_IS_ZERO_FILTER_EN
  assign keep_s   = (sc_is_cnt != {CNT_WIDTH{1'b0}});
`else
  assign keep_s   = 1'b1;
`endif
  assign full_s   = (num_q == NUM_MAX);
  assign ins_s    = accept_s && keep_s && !full_s;
  assign drop_s   = accept_s && keep_s && full_s;
  assign xfer_s   = drain_s && !ht_is_not_ready;
  assign last_s   = (num_q == {NUM_W{1'b0}}) || (NUM_W'(rd_ptr_q) == (num_q - NUM_W'(1)));

  // Equal counts are never "after", so a new entry settles behind its ties.
  always_comb begin
    after_s = {MAX_SYM{1'b0}};
    for (int i = 0; i < MAX_SYM; i++) begin
      if (DESCEND != 0) begin
        after_s[i] = !vld_q[i] || (cnt_q[i] < sc_is_cnt);
      end else begin
        after_s[i] = !vld_q[i] || (cnt_q[i] > sc_is_cnt);
      end
    end
  end

  // Next-state: shift-insert while filling, walk the read pointer while draining.
  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    sym_d    = sym_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    ovfl_d   = ovfl_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    case (state_q)
      ST_FILL: begin
        if (ins_s) begin
          if (after_s[0]) begin
            vld_d[0] = 1'b1;
            sym_d[0] = sc_is_sym;
            cnt_d[0] = sc_is_cnt;
          end else begin
            vld_d[0] = vld_q[0];
          end
          for (int i = 1; i < MAX_SYM; i++) begin
            if (after_s[i-1]) begin
              vld_d[i] = vld_q[i-1];
              sym_d[i] = sym_q[i-1];
              cnt_d[i] = cnt_q[i-1];
            end else if (after_s[i]) begin
              vld_d[i] = 1'b1;
              sym_d[i] = sc_is_sym;
              cnt_d[i] = sc_is_cnt;
            end else begin
              vld_d[i] = vld_q[i];
            end
          end
          num_d = num_q + NUM_W'(1);
        end else begin
          num_d = num_q;
        end
        if (drop_s) begin
          ovfl_d = 1'b1;
        end else begin
          ovfl_d = ovfl_q;
        end
        if (accept_s && sc_is_eob) begin
          seq_d   = sc_is_seq_id;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (xfer_s) begin
          if (last_s) begin
            vld_d    = {MAX_SYM{1'b0}};
            num_d    = {NUM_W{1'b0}};
            ovfl_d   = 1'b0;
            rd_ptr_d = {IDX_W{1'b0}};
            state_d  = ST_FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + IDX_W'(1);
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and entry array registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      vld_q    <= {MAX_SYM{1'b0}};
      num_q    <= {NUM_W{1'b0}};
      ovfl_q   <= 1'b0;
      rd_ptr_q <= {IDX_W{1'b0}};
      seq_q    <= {SEQID_WIDTH{1'b0}};
      for (int i = 0; i < MAX_SYM; i++) begin
        sym_q[i] <= {DAT_WIDTH{1'b0}};
        cnt_q[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      num_q    <= num_d;
      ovfl_q   <= ovfl_d;
      rd_ptr_q <= rd_ptr_d;
      seq_q    <= seq_d;
      for (int i = 0; i < MAX_SYM; i++) begin
        sym_q[i] <= sym_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign is_sc_rd      = accept_s;
  assign is_ht_vld     = drain_s;
  assign is_ht_sym     = (drain_s && vld_q[rd_ptr_q]) ? sym_q[rd_ptr_q] : {DAT_WIDTH{1'b0}};
  assign is_ht_cnt     = (drain_s && vld_q[rd_ptr_q]) ? cnt_q[rd_ptr_q] : {CNT_WIDTH{1'b0}};
  assign is_ht_last    = drain_s && last_s;
  assign is_ht_seq_id  = drain_s ? seq_q : {SEQID_WIDTH{1'b0}};
  assign is_ht_num_sym = drain_s ? num_q : {NUM_W{1'b0}};
  assign is_ht_ovfl    = drain_s && last_s && ovfl_q;
`ifdef CR_HUF_COMP_IS_ZERO_FILTER_EN
  assign is_ht_empty   = drain_s && (num_q == {NUM_W{1'b0}});
`else
  assign is_ht_empty   = 1'b0;
`endif

endmodule

// File: tb/tb_cr_huf_comp_is_sort.sv
// Bench for cr_huf_comp_is_sort: three configurations share one stimulus stream and are scored against a stable-sort model.
module tb_cr_huf_comp_is_sort;

  typedef struct {
    int sym; int cnt; int last; int num; int seq; int ovfl; int empty;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sc_vld, sc_eob, nr;
  logic [8:0] sc_sym;
  logic [15:0] sc_cnt;
  logic [3:0] sc_seq;

  logic        rd_o [3];
  logic        vld_o [3];
  logic [8:0]  sym_o [3];
  logic [15:0] cnt_o [3];
  logic        last_o [3];
  logic [3:0]  seq_o [3];
  logic        ovfl_o [3];
  logic        empty_o [3];
  logic [5:0]  num0;
  logic [2:0]  num1;
  logic [3:0]  num2;

  int n_vec = 0;
  int n_err = 0;
  int blk_sym[$];
  int blk_cnt[$];
  int blk_seq;
  beat_t obs0[$], obs1[$], obs2[$];

  cr_huf_comp_is_sort #(.MAX_SYM(32), .DESCEND(0)) u_asc (
    .clk(clk), .rst_n(rst_n), .sc_is_vld(sc_vld), .sc_is_sym(sc_sym), .sc_is_cnt(sc_cnt),
    .sc_is_seq_id(sc_seq), .sc_is_eob(sc_eob), .is_sc_rd(rd_o[0]), .is_ht_vld(vld_o[0]),
    .is_ht_sym(sym_o[0]), .is_ht_cnt(cnt_o[0]), .is_ht_last(last_o[0]), .is_ht_seq_id(seq_o[0]),
    .is_ht_num_sym(num0), .is_ht_ovfl(ovfl_o[0]), .is_ht_empty(empty_o[0]), .ht_is_not_ready(nr));

  cr_huf_comp_is_sort #(.MAX_SYM(4), .DESCEND(0)) u_small (
    .clk(clk), .rst_n(rst_n), .sc_is_vld(sc_vld), .sc_is_sym(sc_sym), .sc_is_cnt(sc_cnt),
    .sc_is_seq_id(sc_seq), .sc_is_eob(sc_eob), .is_sc_rd(rd_o[1]), .is_ht_vld(vld_o[1]),
    .is_ht_sym(sym_o[1]), .is_ht_cnt(cnt_o[1]), .is_ht_last(last_o[1]), .is_ht_seq_id(seq_o[1]),
    .is_ht_num_sym(num1), .is_ht_ovfl(ovfl_o[1]), .is_ht_empty(empty_o[1]), .ht_is_not_ready(nr));

  cr_huf_comp_is_sort #(.MAX_SYM(8), .DESCEND(1)) u_desc (
    .clk(clk), .rst_n(rst_n), .sc_is_vld(sc_vld), .sc_is_sym(sc_sym), .sc_is_cnt(sc_cnt),
    .sc_is_seq_id(sc_seq), .sc_is_eob(sc_eob), .is_sc_rd(rd_o[2]), .is_ht_vld(vld_o[2]),
    .is_ht_sym(sym_o[2]), .is_ht_cnt(cnt_o[2]), .is_ht_last(last_o[2]), .is_ht_seq_id(seq_o[2]),
    .is_ht_num_sym(num2), .is_ht_ovfl(ovfl_o[2]), .is_ht_empty(empty_o[2]), .ht_is_not_ready(nr));

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int max_of(input int d);
    case (d)
      0: return 32;
      1: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int num_of(input int d);
    case (d)
      0: return int'(num0);
      1: return int'(num1);
      default: return int'(num2);
    endcase
  endfunction

  // Reference: first max_sym non-filtered beats survive, then a stable sort by count.
  task automatic build_exp(input int max_sym, input bit desc, input int seq, output beat_t e[$]);
    int ks[$];
    int kc[$];
    int ov;
    int t;
    ov = 0;
    e.delete();
    for (int i = 0; i < blk_sym.size(); i++) begin
`ifdef CR_HUF_COMP_IS_ZERO_FILTER_EN
      if (blk_cnt[i] == 0) continue;
`endif
      if (ks.size() < max_sym) begin
        ks.push_back(blk_sym[i]);
        kc.push_back(blk_cnt[i]);
      end else begin
        ov = 1;
      end
    end
    for (int p = 0; p < ks.size(); p++) begin
      for (int j = 0; j + 1 < ks.size(); j++) begin
        if (desc ? (kc[j] < kc[j+1]) : (kc[j] > kc[j+1])) begin
          t = kc[j]; kc[j] = kc[j+1]; kc[j+1] = t;
          t = ks[j]; ks[j] = ks[j+1]; ks[j+1] = t;
        end
      end
    end
    if (ks.size() == 0) begin
      e.push_back('{sym: 0, cnt: 0, last: 1, num: 0, seq: seq, ovfl: ov, empty: 1});
    end else begin
      for (int i = 0; i < ks.size(); i++) begin
        e.push_back('{sym: ks[i], cnt: kc[i], last: (i == ks.size() - 1) ? 1 : 0,
                      num: ks.size(), seq: seq,
                      ovfl: (i == ks.size() - 1) ? ov : 0, empty: 0});
      end
    end
  endtask

  // Monitor: collects transferred beats and checks that stalled beats hold steady.
  beat_t prev_b [3];
  bit    prev_stall [3];
  always @(negedge clk) begin : mon
    beat_t b;
    #2;
    for (int d = 0; d < 3; d++) begin
      b = '{sym: int'(sym_o[d]), cnt: int'(cnt_o[d]), last: int'(last_o[d]), num: num_of(d),
            seq: int'(seq_o[d]), ovfl: int'(ovfl_o[d]), empty: int'(empty_o[d])};
      if (!rst_n) begin
        prev_stall[d] = 1'b0;
      end else begin
        if (prev_stall[d]) begin
          check_eq($sformatf("d%0d stall vld", d), vld_o[d], 1);
          check_eq($sformatf("d%0d stall sym", d), b.sym, prev_b[d].sym);
          check_eq($sformatf("d%0d stall cnt", d), b.cnt, prev_b[d].cnt);
          check_eq($sformatf("d%0d stall last", d), b.last, prev_b[d].last);
        end
        if (vld_o[d] && !nr) begin
          case (d)
            0: obs0.push_back(b);
            1: obs1.push_back(b);
            default: obs2.push_back(b);
          endcase
        end
        prev_stall[d] = vld_o[d] && nr;
        prev_b[d] = b;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s d%0d is_sc_rd", tag, d), rd_o[d], 0);
      check_eq($sformatf("%s d%0d vld", tag, d), vld_o[d], 0);
      check_eq($sformatf("%s d%0d last", tag, d), last_o[d], 0);
      check_eq($sformatf("%s d%0d ovfl", tag, d), ovfl_o[d], 0);
      check_eq($sformatf("%s d%0d empty", tag, d), empty_o[d], 0);
      check_eq($sformatf("%s d%0d sym", tag, d), sym_o[d], 0);
      check_eq($sformatf("%s d%0d cnt", tag, d), cnt_o[d], 0);
      check_eq($sformatf("%s d%0d num", tag, d), num_of(d), 0);
    end
  endtask

  task automatic send_block(input int seq);
    for (int i = 0; i < blk_sym.size(); i++) begin
      @(negedge clk);
      sc_vld = 1'b1;
      sc_sym = 9'(blk_sym[i]);
      sc_cnt = 16'(blk_cnt[i]);
      sc_eob = (i == blk_sym.size() - 1);
      sc_seq = sc_eob ? 4'(seq) : 4'($urandom_range(0, 15));
      nr = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
        check_eq($sformatf("d%0d is_sc_rd fill", d), rd_o[d], 1);
        check_eq($sformatf("d%0d vld in fill", d), vld_o[d], 0);
      end
    end
    @(negedge clk);
    sc_vld = 1'b0;
    sc_eob = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_eq($sformatf("d%0d vld latency", d), vld_o[d], 1);
  endtask

  // bp_mode: 0 none, 1 hold beat 2 for three cycles, 2 random backpressure
  task automatic drain(input int bp_mode);
    bit any_v, all_v, done;
    done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      any_v = 1'b0;
      all_v = 1'b1;
      for (int d = 0; d < 3; d++) begin
        any_v = any_v | vld_o[d];
        all_v = all_v & vld_o[d];
      end
      if (!any_v) begin
        done = 1'b1;
        break;
      end
      case (bp_mode)
        1: nr = (cyc <= 2);
        2: nr = ($urandom_range(0, 2) == 0);
        default: nr = 1'b0;
      endcase
      sc_vld = all_v;
      sc_sym = 9'($urandom_range(0, 511));
      sc_cnt = 16'($urandom_range(0, 20));
      sc_eob = 1'b0;
      #1;
      if (all_v) begin
        for (int d = 0; d < 3; d++) check_eq($sformatf("d%0d is_sc_rd drain", d), rd_o[d], 0);
      end
    end
    sc_vld = 1'b0;
    nr = 1'b0;
    check_eq("drain completes", done, 1);
  endtask

  task automatic cmp_block(input int d, input beat_t obs[$]);
    beat_t e[$];
    int n;
    build_exp(max_of(d), d == 2, blk_seq, e);
    check_eq($sformatf("d%0d beat count", d), obs.size(), e.size());
    n = (obs.size() < e.size()) ? obs.size() : e.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("d%0d b%0d sym", d, i), obs[i].sym, e[i].sym);
      check_eq($sformatf("d%0d b%0d cnt", d, i), obs[i].cnt, e[i].cnt);
      check_eq($sformatf("d%0d b%0d last", d, i), obs[i].last, e[i].last);
      check_eq($sformatf("d%0d b%0d num_sym", d, i), obs[i].num, e[i].num);
      check_eq($sformatf("d%0d b%0d seq_id", d, i), obs[i].seq, e[i].seq);
      check_eq($sformatf("d%0d b%0d ovfl", d, i), obs[i].ovfl, e[i].ovfl);
      check_eq($sformatf("d%0d b%0d empty", d, i), obs[i].empty, e[i].empty);
    end
  endtask

  task automatic run_block(input int seq, input int bp_mode);
    blk_seq = seq;
    obs0.delete(); obs1.delete(); obs2.delete();
    send_block(seq);
    drain(bp_mode);
    cmp_block(0, obs0);
    cmp_block(1, obs1);
    cmp_block(2, obs2);
  endtask

  initial begin
    rst_n = 1'b0; sc_vld = 1'b0; sc_sym = 9'd0; sc_cnt = 16'd0;
    sc_seq = 4'd0; sc_eob = 1'b0; nr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    blk_sym = {5, 2, 9, 1};  blk_cnt = {40, 7, 40, 3};  run_block(3, 0);
    run_block(3, 1);
    blk_sym = {10, 11, 12, 13, 14, 15};  blk_cnt = {6, 5, 4, 3, 2, 1};  run_block(5, 2);
    blk_sym = {0, 1, 2};  blk_cnt = {8, 8, 9};  run_block(7, 0);
    blk_sym = {4, 7};  blk_cnt = {0, 0};  run_block(2, 0);

    // Reset while the second of four beats is on the output.
    blk_sym = {3, 8, 6, 11};  blk_cnt = {30, 10, 20, 5};
    send_block(9);
    @(negedge clk);
    #1;
    check_eq("pre-reset beat2 sym", sym_o[0], 8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-drain reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    blk_sym = {20, 21, 22};  blk_cnt = {9, 1, 5};  run_block(12, 0);

    for (int b = 0; b < 12; b++) begin
      int len;
      len = $urandom_range(1, 40);
      blk_sym.delete();
      blk_cnt.delete();
      for (int i = 0; i < len; i++) begin
        blk_sym.push_back($urandom_range(0, 511));
        blk_cnt.push_back((b % 3 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 12));
      end
      run_block($urandom_range(0, 15), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr_huf_comp_is_sort.md
Name: cr_huf_comp_is_sort

Overview:
- Parametrised insertion sorter for the Huffman compressor; the generalised successor to the per-alphabet insert-sort wrappers.
- Accepts one (symbol, count) pair per cycle from the symbol counter, keeps a register array sorted by ascending count, and on end-of-block drains the sorted list to the Huffman tree builder.
- Width, depth and sort direction are parameters; the block also reports overflow and symbol count per block.

Parameters:
- DAT_WIDTH, 9, symbol index width.
- CNT_WIDTH, 16, frequency count width.
- MAX_SYM, 32, sorter depth in entries (>=2).
- SEQID_WIDTH, 4, sequence id width.
- DESCEND, 0: 0 sorts ascending by count; 1 sorts descending.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sc_is_vld  in  1  input beat valid.
- sc_is_sym  in  DAT_WIDTH  symbol.
- sc_is_cnt  in  CNT_WIDTH  symbol frequency.
- sc_is_seq_id  in  SEQID_WIDTH  block sequence id.
- sc_is_eob  in  1  beat is last of block.
- is_sc_rd  out  1  input beat accepted this cycle.
- is_ht_vld  out  1  output beat valid.
- is_ht_sym  out  DAT_WIDTH  sorted symbol.
- is_ht_cnt  out  CNT_WIDTH  its count.
- is_ht_last  out  1  last beat of block.
- is_ht_seq_id  out  SEQID_WIDTH  block sequence id.
- is_ht_num_sym  out  $clog2(MAX_SYM+1)  entries in block, valid while is_ht_vld.
- is_ht_ovfl  out  1  block exceeded MAX_SYM; qualified with is_ht_last.
- is_ht_empty  out  1  block holds no entries; beat carries no symbol.
- ht_is_not_ready  in  1  downstream backpressure.

Behaviour:
- Reset: state=FILL; all entry valid bits 0; num=0; ovfl=0; rd_ptr=0.
- Reset outputs: is_sc_rd=0, is_ht_vld=0, is_ht_last=0, is_ht_ovfl=0, is_ht_empty=0; data outputs 0.
- Reset mid-drain discards the block.
- Output path: all outputs derive from registers only, with no combinational path from ht_is_not_ready to is_ht_vld. is_sc_rd = sc_is_vld && state==FILL (combinational from sc_is_vld).
- FILL, accepted beat: slot i is "after" iff !valid[i], or cnt[i] > new_cnt (< for DESCEND).
  - Slot i takes the new entry if it is after and (i==0 or slot i-1 is not after).
  - Slot i takes entry[i-1] if slot i-1 is after.
  - Otherwise slot i holds.
  - Ties are stable: a new entry lands behind equal counts.
- Full: if num==MAX_SYM the beat is accepted but dropped, and ovfl is set sticky for the block.
- Block end: on an accepted beat with sc_is_eob, the beat is inserted (or dropped) and seq_id is latched. Next state is DRAIN, so is_ht_vld rises the cycle after eob is accepted (1-cycle latency). is_sc_rd is 0 throughout DRAIN.
- DRAIN: the output presents entry[rd_ptr]. A beat transfers when is_ht_vld && !ht_is_not_ready, then rd_ptr increments.
  - is_ht_last = (rd_ptr==num-1), or is_ht_empty when num==0.
  - On transfer of the last beat: clear valid bits, num, ovfl and rd_ptr; return to FILL. A new beat can be accepted the following cycle.
- Stall: while ht_is_not_ready=1, all outputs hold stable.
- Empty block (only reachable with the filter below): one beat with is_ht_empty=1, is_ht_last=1, num_sym=0.
- Width rule: counts are compared unsigned. num saturates at MAX_SYM.

Optional Feature:
- Macro: CR_HUF_COMP_IS_ZERO_FILTER_EN.
- Defined: beats with sc_is_cnt==0 are accepted (is_sc_rd=1) but not inserted and not counted; eob is still honoured; an all-zero block yields the single empty beat.
- Undefined: zero-count beats are inserted like any other entry (they sort first when ascending), and is_ht_empty is tied 0.

Test Plan:
- Basic sort: MAX_SYM=32, DESCEND=0. Beats (sym,cnt) = (5,40),(2,7),(9,40),(1,3,eob), seq_id=3 -> next cycle output (1,3),(2,7),(5,40),(9,40); last on 4th beat; num_sym=4; seq_id=3; ovfl=0.
- Backpressure: same block with ht_is_not_ready high for 3 cycles at beat 2 -> beat 2 held stable for 3 cycles; no beat lost or duplicated; is_sc_rd=0 until the last beat transfers.
- Overflow: MAX_SYM=4; 6 beats with cnts 6,5,4,3,2,1 (eob on the 6th) -> output 3,4,5,6; num_sym=4; is_ht_ovfl=1 on the last beat.
- Descending ties: DESCEND=1; (0,8),(1,8),(2,9,eob) -> output (2,9),(0,8),(1,8).
- Zero filter: with the macro defined, block (4,0),(7,0,eob) -> single beat: is_ht_empty=1, last=1, num_sym=0. With the macro undefined -> two beats (4,0),(7,0).
- Reset mid-drain: assert rst_n low during beat 2 of a 4-entry drain -> all outputs 0 immediately; after release, a new block sorts correctly with no stale entries.
